// File: rtl/aclk_disp_pkg.sv
// rtl/aclk_disp_pkg.sv - shared constants, types and 7-segment encoding for the alarm-clock display scanner
//
// Contents:
//   NUM_DIGITS     number of multiplexed digits (hh:mm:ss)
//   digit_idx_t    scan index, 5 = hour tens ... 0 = second units
//   SEG_BLANK      all segments off (active-low)
//   SEG_DASH       segment g only (active-low), shown for out-of-range fields
//   time_snap_t    one frame's worth of sampled time plus alarm flag
//   seg_encode()   BCD digit 0-9 to active-low segments, seg[0]=a ... seg[6]=g
package aclk_disp_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef struct packed {
        logic [4:0] hours;
        logic [5:0] minutes;
        logic [5:0] seconds;
        logic       alarm;
    } time_snap_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/aclk_disp_scan_if.sv
// rtl/aclk_disp_scan_if.sv - time inputs and multiplexed LED display outputs of the display scanner
//
// Signals:
//   hours[4:0], minutes[5:0], seconds[5:0]  binary time from the alarm clock
//   alarm_active                            alarm ringing, display blinks while high
//   an[5:0]                                 digit enables, one-hot active-low, an[5]=hour tens
//   seg[6:0]                                segments a-g, active-low, seg[0]=a
//   dp                                      decimal point, active-low
// Modports:
//   master  alarm-clock side (drives time, observes display)
//   slave   display scanner side (takes time, drives display)
interface aclk_disp_scan_if;

    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       alarm_active;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output hours, minutes, seconds, alarm_active,
        input  an, seg, dp
    );

    modport slave (
        input  hours, minutes, seconds, alarm_active,
        output an, seg, dp
    );

endinterface

// File: rtl/aclk_bin2bcd.sv
// rtl/aclk_bin2bcd.sv - 6-bit binary to two BCD digits for one time field
//
// Ports:
//   bin[5:0]    binary value, meaningful for 0-59
//   tens[3:0]   bin / 10
//   units[3:0]  bin % 10
// Values 60-63 produce tens=6 and are masked by the caller.
module aclk_bin2bcd (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [5:0] tens_x10;

    always_comb begin
        if (bin >= 6'd60)      tens = 4'd6;
        else if (bin >= 6'd50) tens = 4'd5;
        else if (bin >= 6'd40) tens = 4'd4;
        else if (bin >= 6'd30) tens = 4'd3;
        else if (bin >= 6'd20) tens = 4'd2;
        else if (bin >= 6'd10) tens = 4'd1;
        else                   tens = 4'd0;
        tens_x10 = {2'b00, tens} * 6'd10;
        units    = 4'(bin - tens_x10);
    end

endmodule

// File: rtl/aclk_disp_scan.sv
// rtl/aclk_disp_scan.sv - six-digit multiplexed 7-segment scanner for an alarm clock with blink on alarm
//
// Parameters:
//   SCAN_DIV      clk cycles per digit slot (>=2)
//   BLINK_FRAMES  full scan frames per blink half-period (>=1)
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   disp   aclk_disp_scan_if.slave: hours/minutes/seconds/alarm_active in, an/seg/dp out
// Build option:
//   ACLK_DISP_12H_EN  defined: 12-hour hours, blank leading hour tens, PM on the hour-tens dp
//                     undefined: 24-hour hours with leading zero, hour-tens dp dark
module aclk_disp_scan
    import aclk_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic         clk,
    input  logic         reset,
    aclk_disp_scan_if.slave disp
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam digit_idx_t IDX_FIRST = digit_idx_t'(NUM_DIGITS - 1);
`ifdef ACLK_DISP_12H_EN
    localparam bit HOUR_TENS_BLANK = 1'b1;
`else
    localparam bit HOUR_TENS_BLANK = 1'b0;
`endif

    logic [PW-1:0] presc;
    digit_idx_t    idx, idx_n;
    logic          scan_live;       // set once the first tick after reset has started a frame
    time_snap_t    snap, snap_n, live;
    logic [FW-1:0] fcnt, fcnt_n;
    logic          phase, phase_n;
    logic [5:0]    an_q, an_n;
    logic [6:0]    seg_q, seg_n;
    logic          dp_q, dp_n;

    logic          tick, frame_start;
    logic [4:0]    hrs_disp;
    logic          pm_lit, hour_bad, min_bad, sec_bad;
    logic [3:0]    h_tens, h_units, m_tens, m_units, s_tens, s_units;

    assign live        = {disp.hours, disp.minutes, disp.seconds, disp.alarm_active};
    assign tick        = (presc == PW'(SCAN_DIV - 1));
    // The very first tick after reset opens a frame at index 5 instead of stepping past it.
    assign frame_start = tick && (!scan_live || idx == 3'd0);

    always_comb begin
        idx_n   = idx;
        snap_n  = snap;
        fcnt_n  = fcnt;
        phase_n = phase;
        if (frame_start) begin
            idx_n  = IDX_FIRST;
            snap_n = live;
        end else if (tick) begin
            idx_n = idx - 3'd1;
        end
        // Frames are only counted once a ringing alarm is already on screen, so the
        // first blink half is always BLINK_FRAMES full lit frames.
        if (!disp.alarm_active) begin
            fcnt_n  = '0;
            phase_n = 1'b0;
        end else if (frame_start && snap.alarm) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt_n  = '0;
                phase_n = ~phase;
            end else begin
                fcnt_n = fcnt + FW'(1);
            end
        end
    end

    // Display content is derived from the next-state snapshot so a new frame shows
    // its fresh time on its very first digit.
    assign hour_bad = (snap_n.hours > 5'd23);
    assign min_bad  = (snap_n.minutes > 6'd59);
    assign sec_bad  = (snap_n.seconds > 6'd59);

    always_comb begin
        hrs_disp = snap_n.hours;
        pm_lit   = 1'b0;
`ifdef ACLK_DISP_12H_EN
        if (snap_n.hours == 5'd0)
            hrs_disp = 5'd12;
        else if (snap_n.hours > 5'd12)
            hrs_disp = snap_n.hours - 5'd12;
        pm_lit = !hour_bad && (snap_n.hours >= 5'd12);
`endif
    end

    aclk_bin2bcd u_bcd_hours   (.bin({1'b0, hrs_disp}), .tens(h_tens), .units(h_units));
    aclk_bin2bcd u_bcd_minutes (.bin(snap_n.minutes),   .tens(m_tens), .units(m_units));
    aclk_bin2bcd u_bcd_seconds (.bin(snap_n.seconds),   .tens(s_tens), .units(s_units));

    always_comb begin
        seg_n = SEG_BLANK;
        case (idx_n)
            3'd5: seg_n = hour_bad ? SEG_DASH :
                          (HOUR_TENS_BLANK && h_tens == 4'd0) ? SEG_BLANK : seg_encode(h_tens);
            3'd4: seg_n = hour_bad ? SEG_DASH : seg_encode(h_units);
            3'd3: seg_n = min_bad  ? SEG_DASH : seg_encode(m_tens);
            3'd2: seg_n = min_bad  ? SEG_DASH : seg_encode(m_units);
            3'd1: seg_n = sec_bad  ? SEG_DASH : seg_encode(s_tens);
            3'd0: seg_n = sec_bad  ? SEG_DASH : seg_encode(s_units);
            default: seg_n = SEG_BLANK;
        endcase
        dp_n = ~((idx_n == 3'd4) || (idx_n == 3'd2) || (idx_n == 3'd5 && pm_lit));
        an_n = (snap_n.alarm && phase_n) ? 6'b111111 : ~(6'b000001 << idx_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            idx       <= IDX_FIRST;
            scan_live <= 1'b0;
            snap      <= '0;
            fcnt      <= '0;
            phase     <= 1'b0;
            an_q      <= 6'b111111;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            presc     <= tick ? '0 : presc + PW'(1);
            idx       <= idx_n;
            scan_live <= scan_live | tick;
            snap      <= snap_n;
            fcnt      <= fcnt_n;
            phase     <= phase_n;
            if (tick) begin
                an_q  <= an_n;
                seg_q <= seg_n;
                dp_q  <= dp_n;
            end
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule

// File: tb/tb_aclk_disp_scan.sv
// tb/tb_aclk_disp_scan.sv - self-checking bench for aclk_disp_scan (SCAN_DIV=4, BLINK_FRAMES=2)
module tb_aclk_disp_scan;

    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = 6 * SD;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    aclk_disp_scan_if dif ();

    aclk_disp_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk  (clk),
        .reset(reset),
        .disp (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    h;
        int    m;
        int    s;
        string digits;
        logic  pm;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Active-high gfedcba patterns, inverted for the active-low display; -1 blank, -2 dash.
    function automatic logic [6:0] ref_glyph(input int g);
        logic [6:0] hi;
        case (g)
            0: hi = 7'b0111111;  1: hi = 7'b0000110;  2: hi = 7'b1011011;
            3: hi = 7'b1001111;  4: hi = 7'b1100110;  5: hi = 7'b1101101;
            6: hi = 7'b1111101;  7: hi = 7'b0000111;  8: hi = 7'b1111111;
            9: hi = 7'b1101111; -2: hi = 7'b1000000;
            default: hi = 7'b0000000;
        endcase
        return ~hi;
    endfunction

    function automatic logic [41:0] ref_frame(input int h, input int m, input int s);
        int g [6];
        int hv;
        logic [41:0] f;
        if (h > 23) begin
            g[5] = -2; g[4] = -2;
        end else begin
`ifdef ACLK_DISP_12H_EN
            hv = h % 12;
            if (hv == 0) hv = 12;
            g[5] = (hv / 10 == 0) ? -1 : hv / 10;
            g[4] = hv % 10;
`else
            hv = h;
            g[5] = hv / 10;
            g[4] = hv % 10;
`endif
        end
        if (m > 59) begin g[3] = -2; g[2] = -2; end
        else        begin g[3] = m / 10; g[2] = m % 10; end
        if (s > 59) begin g[1] = -2; g[0] = -2; end
        else        begin g[1] = s / 10; g[0] = s % 10; end
        for (int p = 0; p < 6; p++) f[p*7 +: 7] = ref_glyph(g[p]);
        return f;
    endfunction

    function automatic logic [5:0] ref_dp(input int h);
        logic [5:0] d;
        d = 6'b101011;
`ifdef ACLK_DISP_12H_EN
        if (h >= 12 && h <= 23) d[5] = 1'b0;
`endif
        return d;
    endfunction

    function automatic logic [41:0] str_frame(input string d);
        logic [41:0] f;
        byte c;
        int g;
        for (int i = 0; i < 6; i++) begin
            c = d[i];
            if (c == 8'h2D)      g = -2;
            else if (c == 8'h20) g = -1;
            else                 g = int'(c) - 48;
            f[(5 - i)*7 +: 7] = ref_glyph(g);
        end
        return f;
    endfunction

    task automatic set_time(input int h, input int m, input int s);
        dif.hours   = 5'(h);
        dif.minutes = 6'(m);
        dif.seconds = 6'(s);
    endtask

    // Returns at the negedge of the first cycle of a fresh index-5 slot.
    task automatic align();
        int n;
        n = 0;
        while (dif.an == 6'b011111 && n < 60) begin @(negedge clk); n++; end
        while (dif.an != 6'b011111 && n < 120) begin @(negedge clk); n++; end
        if (dif.an != 6'b011111) begin
            total++;
            $display("FAIL align: timed out with an=%b", dif.an);
        end
    endtask

    // Checks one full frame, every cycle of every slot; leaves the bench aligned to the next frame.
    task automatic check_frame(input string name, input logic [41:0] eseg, input logic [5:0] edp);
        logic [13:0] act, exp, smp;
        int pos;
        for (int k = 0; k < 6; k++) begin
            pos = 5 - k;
            exp = {~(6'b000001 << pos), eseg[pos*7 +: 7], edp[pos]};
            act = {dif.an, dif.seg, dif.dp};
            for (int j = 0; j < SD; j++) begin
                smp = {dif.an, dif.seg, dif.dp};
                if (smp !== exp && act === exp) act = smp;
                @(negedge clk);
            end
            chk($sformatf("%s slot%0d {an,seg,dp}", name, pos), 64'(act), 64'(exp));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [41:0] fr;
        int h, m, s;
        passed = 0;
        total  = 0;

`ifdef ACLK_DISP_12H_EN
        tbl[0] = '{0,  0,  0,  "120000", 1'b0};
        tbl[1] = '{15, 30, 0,  " 33000", 1'b1};
        tbl[2] = '{12, 5,  9,  "120509", 1'b1};
        tbl[3] = '{23, 59, 59, "115959", 1'b1};
        tbl[4] = '{9,  10, 0,  " 91000", 1'b0};
        tbl[5] = '{25, 60, 5,  "----05", 1'b0};
`else
        tbl[0] = '{13, 7,  59, "130759", 1'b0};
        tbl[1] = '{25, 60, 5,  "----05", 1'b0};
        tbl[2] = '{0,  0,  0,  "000000", 1'b0};
        tbl[3] = '{23, 59, 59, "235959", 1'b0};
        tbl[4] = '{24, 59, 60, "--59--", 1'b0};
        tbl[5] = '{9,  10, 0,  "091000", 1'b0};
`endif

        reset = 1'b1;
        set_time(0, 0, 0);
        dif.alarm_active = 1'b0;
        #3;
        chk("reset an", 64'(dif.an), 64'(6'b111111));
        chk("reset seg", 64'(dif.seg), 64'(7'b1111111));
        chk("reset dp", 64'(dif.dp), 64'(1'b1));
        repeat (3) @(negedge clk);
        reset = 1'b0;

        align();
        check_frame("boot", ref_frame(0, 0, 0), ref_dp(0));

        for (int i = 0; i < 6; i++) begin
            set_time(tbl[i].h, tbl[i].m, tbl[i].s);
            align();
            check_frame($sformatf("table%0d", i), str_frame(tbl[i].digits),
                        {~tbl[i].pm, 5'b01011});
        end

        for (int i = 0; i < 8; i++) begin
            h = $urandom_range(0, 31);
            m = $urandom_range(0, 63);
            s = $urandom_range(0, 63);
            set_time(h, m, s);
            align();
            check_frame($sformatf("rand%0d h%0d m%0d s%0d", i, h, m, s), ref_frame(h, m, s), ref_dp(h));
        end

        // Minutes change after the frame has started: this frame keeps 30, next shows 31.
        set_time(13, 30, 7);
        align();
        dif.minutes = 6'd31;
        check_frame("midframe old", ref_frame(13, 30, 7), ref_dp(13));
        check_frame("midframe new", ref_frame(13, 31, 7), ref_dp(13));

        // Alarm blink: frames 1,2 lit, 3,4 dark, 5,6 lit, 7 dark.
        set_time(13, 7, 59);
        align();
        dif.alarm_active = 1'b1;
        for (int f = 1; f <= 7; f++) begin
            repeat (FRAME) @(negedge clk);
            chk($sformatf("blink frame%0d an", f), 64'(dif.an),
                64'((((f - 1) / BF) % 2 == 1) ? 6'b111111 : 6'b011111));
        end
        fr = ref_frame(13, 7, 59);
        repeat (SD) @(negedge clk);
        chk("blink dark an", 64'(dif.an), 64'(6'b111111));
        chk("blink dark seg scanning", 64'(dif.seg), 64'(fr[4*7 +: 7]));
        @(negedge clk);
        dif.alarm_active = 1'b0;
        repeat (4) @(negedge clk);
        chk("alarm off relit", 64'(dif.an), 64'(6'b110111));

        // Asynchronous reset while index 2 is displayed.
        set_time(21, 45, 3);
        align();
        repeat (2) align();
        repeat (2 * SD + SD + 1) @(negedge clk);
        chk("pre-reset idx2", 64'(dif.an), 64'(6'b111011));
        reset = 1'b1;
        #1;
        chk("async reset an", 64'(dif.an), 64'(6'b111111));
        chk("async reset seg", 64'(dif.seg), 64'(7'b1111111));
        chk("async reset dp", 64'(dif.dp), 64'(1'b1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (SD - 1) @(negedge clk);
        chk("post-reset dark", 64'(dif.an), 64'(6'b111111));
        @(negedge clk);
        chk("post-reset idx5", 64'(dif.an), 64'(6'b011111));
        check_frame("post-reset frame", ref_frame(21, 45, 3), ref_dp(21));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
